// File: rtl/balanca_pkg.sv
// Shared constants and types for the Balanca price path: divide-by-100 geometry,
// rounding threshold and the converter state encoding.
package balanca_pkg;
  localparam int DIVISOR      = 100;
  localparam int FRAC_W       = 7;
  localparam int ROUND_THRESH = 50;

  typedef enum logic [1:0] {IDLE, DIV, DONE} conv_state_t;
endpackage

// File: rtl/div100_step.sv
// One radix-2 restoring step of a divide-by-100: shift a dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div100_step
  import balanca_pkg::*;
(
  input  logic [FRAC_W-1:0] rem_in,
  input  logic              bit_in,
  output logic [FRAC_W-1:0] rem_out,
  output logic              q_bit
);

  localparam logic [FRAC_W:0] DIV_L = (FRAC_W+1)'(DIVISOR);

  logic [FRAC_W:0] trial;
  logic [FRAC_W:0] diff;

  // rem_in < 100 keeps trial below 200, so FRAC_W+1 bits never overflow
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - DIV_L;
    q_bit   = (trial >= DIV_L);
    rem_out = q_bit ? diff[FRAC_W-1:0] : trial[FRAC_W-1:0];
  end

endmodule

// File: rtl/centimos_euros_seq.sv
// Sequential cents-to-euros converter: saturates the input, divides by 100 one
// bit per cycle and presents euros, cent fraction and rounded euros with valid/ready.
module centimos_euros_seq
  import balanca_pkg::*;
#(
  parameter int CENT_W    = 14,
  parameter int EUR_W     = 8,
  parameter int MAX_CENTS = 9999
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CENT_W-1:0] centimos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EUR_W-1:0]  eurosinteiros,
  output logic [FRAC_W-1:0] eurosfracao,
  output logic [EUR_W-1:0]  eurosround,
  output logic              ovf
);

  localparam int                CNT_W   = (CENT_W > 1) ? $clog2(CENT_W) : 1;
  localparam logic [CENT_W-1:0] MAX_C   = CENT_W'(MAX_CENTS);
  localparam logic [FRAC_W-1:0] ROUND_T = FRAC_W'(ROUND_THRESH);

  if (MAX_CENTS >= (1 << CENT_W)) begin : g_chk_max
    $error("MAX_CENTS does not fit in CENT_W bits");
  end
  if (EUR_W < CENT_W - 6) begin : g_chk_eur
    $error("EUR_W too narrow for floor(2^CENT_W/100)");
  end
  if ((MAX_CENTS / DIVISOR) + 1 > (1 << EUR_W) - 1) begin : g_chk_round
    $error("rounded euro result can overflow EUR_W");
  end

  function automatic logic [CENT_W-1:0] sat_cents(input logic [CENT_W-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  function automatic logic [EUR_W-1:0] round_euro(input logic [EUR_W-1:0] e,
                                                  input logic [FRAC_W-1:0] f);
    return e + EUR_W'(f >= ROUND_T);
  endfunction

  conv_state_t       state_p0, state_nx;
  logic [CNT_W-1:0]  cnt_p0;
  logic              ovf_p0;
  logic [CENT_W-1:0] c_p0;
  logic [FRAC_W-1:0] rem_p0;
  logic [CENT_W-1:0] q_p0;

  logic [FRAC_W-1:0] rem_nx;
  logic              q_bit;
  logic [CENT_W-1:0] q_nx;

  logic [EUR_W-1:0]  eur_p1;
  logic [FRAC_W-1:0] frac_p1;
  logic              ovf_p1;

  logic accept;
  logic last_step;

  assign in_ready  = rst_n & (state_p0 == IDLE);
  assign out_valid = (state_p0 == DONE);
  assign accept    = in_valid & in_ready;
  assign last_step = (state_p0 == DIV) && (cnt_p0 == '0);
  assign q_nx      = {q_p0[CENT_W-2:0], q_bit};

  div100_step u_step (
    .rem_in  (rem_p0),
    .bit_in  (c_p0[CENT_W-1]),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (accept) state_nx = DIV;
      DIV:     if (cnt_p0 == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // stage p0: control, bit counter and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      eur_p1   <= '0;
      frac_p1  <= '0;
      ovf_p1   <= 1'b0;
    end else begin
      state_p0 <= state_nx;
      if (accept) begin
        cnt_p0 <= CNT_W'(CENT_W - 1);
        ovf_p0 <= (centimos > MAX_C);
      end else if (state_p0 == DIV) begin
        cnt_p0 <= cnt_p0 - CNT_W'(1);
      end
      // stage p1: results captured on the final divide step, held through DONE
      if (last_step) begin
        eur_p1  <= EUR_W'(q_nx);
        frac_p1 <= rem_nx;
        ovf_p1  <= ovf_p0;
      end
    end
  end

  // stage p0: dividend/remainder/quotient shift registers
  always_ff @(posedge clk) begin
    if (accept) begin
      c_p0   <= sat_cents(centimos);
      rem_p0 <= '0;
      q_p0   <= '0;
    end else if (state_p0 == DIV) begin
      c_p0   <= c_p0 << 1;
      rem_p0 <= rem_nx;
      q_p0   <= q_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && state_p0 == DONE) begin
      assert ((q_p0 >> EUR_W) == '0);
    end
  end

  assign eurosinteiros = eur_p1;
  assign eurosfracao   = frac_p1;
  assign eurosround    = round_euro(eur_p1, frac_p1);
  assign ovf           = ovf_p1;

endmodule

// File: tb/tb_centimos_euros_seq.sv
// Self-checking bench for centimos_euros_seq: directed literal cases plus a
// randomized sweep checked every cycle against a cents/100 behavioural model.
module tb_centimos_euros_seq;
  localparam int CENT_W = 14;
  localparam int EUR_W  = 8;
  localparam int MAXC   = 9999;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CENT_W-1:0] centimos;
  logic             out_valid;
  logic             out_ready;
  logic [EUR_W-1:0] eurosinteiros;
  logic [6:0]       eurosfracao;
  logic [EUR_W-1:0] eurosround;
  logic             ovf;

  centimos_euros_seq #(.CENT_W(CENT_W), .EUR_W(EUR_W), .MAX_CENTS(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .centimos(centimos), .out_valid(out_valid), .out_ready(out_ready),
    .eurosinteiros(eurosinteiros), .eurosfracao(eurosfracao),
    .eurosround(eurosround), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int acc; } item_t;
  item_t q[$];
  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  int ready_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural expectations straight from the arithmetic definition.
  function automatic int m_clamp(input int c); return (c > MAXC) ? MAXC : c; endfunction
  function automatic int m_eur(input int c);   return m_clamp(c) / 100; endfunction
  function automatic int m_frac(input int c);  return m_clamp(c) % 100; endfunction
  function automatic int m_rnd(input int c);   return m_eur(c) + ((m_frac(c) >= 50) ? 1 : 0); endfunction
  function automatic int m_ovf(input int c);   return (c > MAXC) ? 1 : 0; endfunction

  // Per-cycle compare process: handshake, latency, hold and data vs the model.
  always @(negedge clk) begin
    bit exp_rdy, exp_ov;
    if (!rst_n) begin
      q.delete();
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_eur", int'(eurosinteiros), 0);
      chk("rst_frac", int'(eurosfracao), 0);
      chk("rst_round", int'(eurosround), 0);
      chk("rst_ovf", int'(ovf), 0);
    end else begin
      exp_rdy = (q.size() == 0);
      exp_ov  = (q.size() > 0) && (cyc >= q[0].acc + CENT_W);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      chk("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov && out_valid) begin
        chk("eurosinteiros", int'(eurosinteiros), m_eur(q[0].c));
        chk("eurosfracao", int'(eurosfracao), m_frac(q[0].c));
        chk("eurosround", int'(eurosround), m_rnd(q[0].c));
        chk("ovf", int'(ovf), m_ovf(q[0].c));
      end
      if (exp_ov && out_ready) void'(q.pop_front());
      if (exp_rdy && in_valid) q.push_back('{c: int'(centimos), acc: cyc + 1});
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one value and wait for acceptance; returns the accept edge number.
  task automatic drive(input int v, output int acc);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    centimos = CENT_W'(v);
    acc = -1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; acc = cyc + 1; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    centimos = CENT_W'($urandom);
  endtask

  task automatic wait_out(input int acc, output bit ok);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    if (!ok) chk("result_timeout", 0, 1);
    else chk("latency", cyc - acc, CENT_W);
  endtask

  task automatic conv(input int v, input int e, input int f, input int r, input int o);
    int acc;
    bit ok;
    drive(v, acc);
    wait_out(acc, ok);
    if (ok) begin
      chk($sformatf("lit_eur_%0d", v), int'(eurosinteiros), e);
      chk($sformatf("lit_frac_%0d", v), int'(eurosfracao), f);
      chk($sformatf("lit_round_%0d", v), int'(eurosround), r);
      chk($sformatf("lit_ovf_%0d", v), int'(ovf), o);
    end
  endtask

  initial begin
    int acc;
    int accs[3];
    int b2b[3];
    int specials[8];
    bit ok;
    b2b = '{1234, 9050, 12000};
    specials = '{0, 99, 100, 9999, 10000, 16383, 50, 149};
    rst_n = 1'b0; in_valid = 1'b0; centimos = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    conv(250, 2, 50, 3, 0);
    conv(0, 0, 0, 0, 0);
    conv(99, 0, 99, 1, 0);
    conv(100, 1, 0, 1, 0);
    conv(149, 1, 49, 1, 0);
    conv(12000, 99, 99, 100, 1);

    // Back-pressure hold with an ignored in_valid pulse during the divide.
    ready_mode = 0;
    drive(4321, acc);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b1; centimos = CENT_W'(77);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(acc, ok);
    for (int i = 0; i < 5 && ok; i++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_eur", int'(eurosinteiros), 43);
      chk("hold_frac", int'(eurosfracao), 21);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    ready_mode = 1;
    repeat (3) @(posedge clk);

    // Reset during the fifth divide cycle discards the operation.
    drive(5555, acc);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (CENT_W + 4) @(negedge clk);
    conv(250, 2, 50, 3, 0);

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      centimos = CENT_W'(b2b[k]);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; accs[k] = cyc + 1; end
      end
      if (!ok) chk("b2b_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_spacing_1", accs[1] - accs[0], CENT_W + 2);
    chk("b2b_spacing_2", accs[2] - accs[1], CENT_W + 2);

    // Random sweep with random back-pressure and idle gaps.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int v;
      v = (n % 5 == 0) ? specials[(n / 5) % 8] : int'($urandom_range(0, 16383));
      drive(v, acc);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    ready_mode = 1;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
